// File: rtl/dabble_pkg.sv
// Shared types and elaboration helpers for the double-dabble BCD converter.
package dabble_pkg;

  // Controller sequencing: one ADJUST/SHIFT pair per operand bit, then FINISH.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } dabble_state_t;

  // Iteration counter must hold the value BIN_W itself.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

  // 10^n, used to check that DIGITS covers the operand range.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_ctrl_add3.sv
// Double-dabble digit correction cell: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
module add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  // Correct the digit ahead of the shift.
  always_comb begin
    out_o = in_i;
    if (in_i >= 4'd5) begin
      out_o = in_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_dabble_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3), with a start/busy/done
// handshake and a held BCD result.
// Optional macro BCD_BLANK_MASK_EN adds a leading-zero blanking mask output.
module bcd_dabble_ctrl
  import dabble_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_BLANK_MASK_EN
  output logic [DIGITS-1:0]     blank_mask,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned WW = BW + BIN_W;
  localparam int unsigned CW = cnt_width(BIN_W);

  localparam longint unsigned MaxBin   = (64'd1 << BIN_W) - 64'd1;
  localparam longint unsigned DecRange = pow10(DIGITS);

  if (DecRange <= MaxBin) begin : g_bad_digits
    $error("bcd_dabble_ctrl: DIGITS too small for BIN_W");
  end

  dabble_state_t   state_q, state_d;
  logic [WW-1:0]   work_q, work_d;     // {bcd_work, bin_work}
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   bcd_adj;

  // One correction cell per BCD digit of the working register.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    add3 u_add3 (
      .in_i  (work_q[BIN_W + 4*g +: 4]),
      .out_o (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD_BLANK_MASK_EN
  logic [DIGITS-1:0] mask_q, mask_d, mask_calc;

  // Digit k blanks when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    logic hi_zero;
    mask_calc = '0;
    hi_zero   = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      hi_zero      = hi_zero & (work_q[BIN_W + 4*k +: 4] == 4'd0);
      mask_calc[k] = hi_zero;
    end
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
`ifdef BCD_BLANK_MASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{BW{1'b0}}, bin_in};
          cnt_d   = CW'(BIN_W);
          busy_d  = 1'b1;
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        work_d  = {bcd_adj, work_q[BIN_W-1:0]};
        state_d = SHIFT;
      end
      SHIFT: begin
        work_d  = {work_q[WW-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FINISH : ADJUST;
      end
      FINISH: begin
        bcd_d   = work_q[WW-1 -: BW];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef BCD_BLANK_MASK_EN
        mask_d  = mask_calc;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any running conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef BCD_BLANK_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
`ifdef BCD_BLANK_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
`ifdef BCD_BLANK_MASK_EN
  assign blank_mask = mask_q;
`endif

endmodule

// File: tb/tb_bcd_dabble_ctrl.sv
// Self-checking bench for bcd_dabble_ctrl (BIN_W=8, DIGITS=3): vector table,
// full sweep against a decimal model, and handshake/reset corner sequences.
module tb_bcd_dabble_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
`ifdef BCD_BLANK_MASK_EN
  logic [2:0]  blank_mask;
`endif

  bcd_dabble_ctrl #(
    .BIN_W  (8),
    .DIGITS (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
`ifdef BCD_BLANK_MASK_EN
    .blank_mask (blank_mask),
`endif
    .bcd_out    (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  mask;
  } exp_t;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  mask;
  } vec_t;

  int   checks;
  int   errors;
  int   done_cnt;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal-arithmetic reference, independent of the shift-and-add method.
  function automatic exp_t model(input int v);
    exp_t e;
    e.bcd  = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    e.mask = (v < 10) ? 3'b110 : ((v < 100) ? 3'b100 : 3'b000);
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(posedge clk) begin
    #1;
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
`ifdef BCD_BLANK_MASK_EN
        check("blank_mask", 32'(blank_mask), 32'(e.mask));
`endif
      end
    end
  end

  // Drive start for one edge; on acceptance push the expected result.
  task automatic accept(input logic [7:0] v, input exp_t e);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    sb.push_back(e);
    #1;
    check("busy_on_accept", 32'(busy), 32'(1));
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;  // must not disturb the running conversion
  endtask

  // Count edges until done; returns at done-cycle +1 time unit.
  task automatic wait_done(input int exp_lat, input string name);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 60);
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s: done timeout after %0d edges, expected %0d", name, lat, exp_lat);
    end else begin
      check(name, 32'(lat), 32'(exp_lat));
    end
  endtask

  vec_t vecs[9];

  initial begin
    int snap;
    vecs[0] = '{8'd0,   12'h000, 3'b110};
    vecs[1] = '{8'd255, 12'h255, 3'b000};
    vecs[2] = '{8'd99,  12'h099, 3'b100};
    vecs[3] = '{8'd128, 12'h128, 3'b000};
    vecs[4] = '{8'd7,   12'h007, 3'b110};
    vecs[5] = '{8'd105, 12'h105, 3'b000};
    vecs[6] = '{8'd42,  12'h042, 3'b100};
    vecs[7] = '{8'd9,   12'h009, 3'b110};
    vecs[8] = '{8'd10,  12'h010, 3'b100};

    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    start    = 1'b0;
    bin_in   = 8'd0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_bcd", 32'(bcd_out), 32'(0));
`ifdef BCD_BLANK_MASK_EN
    check("reset_mask", 32'(blank_mask), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors with latency and handshake checks.
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.bcd  = vecs[i].bcd;
      e.mask = vecs[i].mask;
      accept(vecs[i].bin, e);
      wait_done(17, "latency");
      check("busy_low_at_done", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'(0));
    end

    // Full operand sweep.
    for (int v = 0; v < 256; v++) begin
      accept(8'(v), model(v));
      wait_done(17, "sweep_latency");
    end

    // Start while busy is ignored: one done, result of the first operand.
    snap = done_cnt;
    accept(8'd42, model(42));
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start  = 1'b0;
    wait_done(12, "busy_ignore_latency");
    repeat (25) @(posedge clk);
    #1;
    check("busy_ignore_done_count", 32'(done_cnt - snap), 32'(1));

    // Start held across the done cycle: back-to-back with no bubble.
    accept(8'd99, model(99));
    repeat (10) @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd73;
    wait_done(7, "b2b_first_latency");
    @(posedge clk);
    sb.push_back(model(73));
    #1;
    check("b2b_busy", 32'(busy), 32'(1));
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd1;
    wait_done(17, "b2b_second_latency");
    check("b2b_bcd", 32'(bcd_out), 32'(12'h073));

    // Reset mid-conversion aborts without a done pulse.
    accept(8'd150, model(150));
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_bcd", 32'(bcd_out), 32'(0));
    sb.delete();
    snap = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - snap), 32'(0));
    check("abort_bcd_held", 32'(bcd_out), 32'(0));
    accept(8'd150, model(150));
    wait_done(17, "after_abort_latency");
    check("after_abort_bcd", 32'(bcd_out), 32'(12'h150));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
